// File: rtl/conv_3x3_sched.sv
// ----------------------------------------------------------------------------
// conv_3x3_sched: tile/channel-group issue sequencer with credit-throttled tags
// Optional CONV_SCHED_PERF_EN adds stall counters.  Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module conv_3x3_sched #(
  parameter int CG_W    = 6,
  parameter int DIM_W   = 10,
  parameter int CREDITS = 4,
  parameter int CRED_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CG_W-1:0]  cfg_cin_groups,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  output logic             busy,
  output logic             done,
  input  logic             win_ready,
  output logic             win_take,
  output logic [DIM_W-1:0] cur_row,
  output logic [DIM_W-1:0] cur_col,
  output logic [CG_W-1:0]  cur_grp,
  output logic             conv_valid_in,
  output logic             conv_last_channel,
  input  logic             conv_data_valid,
  output logic             res_valid,
  output logic [DIM_W-1:0] res_row,
  output logic [DIM_W-1:0] res_col,
  input  logic             res_ack,
  output logic             err
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      credit_stalls,
  output logic [31:0]      data_stalls
`endif
);

  localparam int PTR_W = (CREDITS > 1) ? $clog2(CREDITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t             state;
  logic [CG_W-1:0]    groups_q;
  logic [DIM_W-1:0]   width_q;
  logic [DIM_W-1:0]   height_q;
  logic [CRED_W-1:0]  credits;
  logic [CRED_W-1:0]  fifo_cnt;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [DIM_W-1:0]   tag_row [CREDITS];
  logic [DIM_W-1:0]   tag_col [CREDITS];

  logic last_grp, last_col, last_row;
  logic take, take_last, fifo_empty, pop, ack_ok, cred_full;

  assign last_grp   = (cur_grp == groups_q - CG_W'(1));
  assign last_col   = (cur_col == width_q - DIM_W'(1));
  assign last_row   = (cur_row == height_q - DIM_W'(1));
  // The final group of a pixel produces a result, so only it needs a credit.
  assign take       = (state == RUN) && win_ready && (!last_grp || (credits != '0));
  assign take_last  = take && last_grp;
  assign fifo_empty = (fifo_cnt == '0);
  assign pop        = conv_data_valid && !fifo_empty;
  assign cred_full  = (credits == CRED_W'(CREDITS));
  assign ack_ok     = res_ack && !cred_full;

  assign win_take  = take;
  assign busy      = (state != IDLE);
  assign res_valid = conv_data_valid;
  assign res_row   = fifo_empty ? '0 : tag_row[rd_ptr];
  assign res_col   = fifo_empty ? '0 : tag_col[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(CREDITS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (take_last) begin
      tag_row[wr_ptr] <= cur_row;
      tag_col[wr_ptr] <= cur_col;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits  <= CRED_W'(CREDITS);
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      err      <= 1'b0;
    end else begin
      case ({take_last, ack_ok})
        2'b10:   credits <= credits - CRED_W'(1);
        2'b01:   credits <= credits + CRED_W'(1);
        default: credits <= credits;
      endcase
      case ({take_last, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CRED_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CRED_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (take_last) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)       rd_ptr <= ptr_inc(rd_ptr);
      if ((conv_data_valid && fifo_empty) || (res_ack && cred_full)) err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      groups_q          <= '0;
      width_q           <= '0;
      height_q          <= '0;
      cur_row           <= '0;
      cur_col           <= '0;
      cur_grp           <= '0;
      conv_valid_in     <= 1'b0;
      conv_last_channel <= 1'b0;
      done              <= 1'b0;
    end else begin
      conv_valid_in     <= take;
      conv_last_channel <= take_last;
      done              <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            groups_q <= cfg_cin_groups;
            width_q  <= cfg_width;
            height_q <= cfg_height;
            cur_row  <= '0;
            cur_col  <= '0;
            cur_grp  <= '0;
            if ((cfg_cin_groups == '0) || (cfg_width == '0) || (cfg_height == '0))
              state <= FIN;
            else
              state <= RUN;
          end
        end
        RUN: begin
          if (take) begin
            if (!last_grp) begin
              cur_grp <= cur_grp + CG_W'(1);
            end else begin
              cur_grp <= '0;
              if (!last_col) begin
                cur_col <= cur_col + DIM_W'(1);
              end else begin
                cur_col <= '0;
                if (!last_row) begin
                  cur_row <= cur_row + DIM_W'(1);
                end else begin
                  cur_row <= '0;
                  state   <= DRAIN;
                end
              end
            end
          end
        end
        DRAIN: begin
          if (fifo_empty) state <= FIN;
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CONV_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles  <= '0;
      credit_stalls <= '0;
      data_stalls   <= '0;
    end else if ((state == IDLE) && start) begin
      stall_cycles  <= '0;
      credit_stalls <= '0;
      data_stalls   <= '0;
    end else if ((state == RUN) && !take) begin
      stall_cycles <= stall_cycles + 32'd1;
      if (win_ready) credit_stalls <= credit_stalls + 32'd1;
      else           data_stalls   <= data_stalls + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_conv_3x3_sched.sv
// ----------------------------------------------------------------------------
// tb_conv_3x3_sched: directed self-checking bench with a fixed-latency conv model
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_conv_3x3_sched;

  localparam int CG_W  = 6;
  localparam int DIM_W = 10;
  localparam int L     = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CG_W-1:0]  cfg_cin_groups = '0;
  logic [DIM_W-1:0] cfg_width = '0;
  logic [DIM_W-1:0] cfg_height = '0;
  logic             win_ready = 1'b0;
  logic             tb_dv = 1'b0;
  logic             tb_ack = 1'b0;
  logic             model_dv = 1'b0;
  logic             model_ack = 1'b0;
  logic             ack_en = 1'b0;
  logic             conv_data_valid;
  logic             res_ack;

  logic             busy, done, win_take, conv_valid_in, conv_last_channel;
  logic             res_valid, err;
  logic [DIM_W-1:0] cur_row, cur_col, res_row, res_col;
  logic [CG_W-1:0]  cur_grp;

  assign conv_data_valid = model_dv | tb_dv;
  assign res_ack         = model_ack | tb_ack;

  conv_3x3_sched dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .cfg_cin_groups    (cfg_cin_groups),
    .cfg_width         (cfg_width),
    .cfg_height        (cfg_height),
    .busy              (busy),
    .done              (done),
    .win_ready         (win_ready),
    .win_take          (win_take),
    .cur_row           (cur_row),
    .cur_col           (cur_col),
    .cur_grp           (cur_grp),
    .conv_valid_in     (conv_valid_in),
    .conv_last_channel (conv_last_channel),
    .conv_data_valid   (conv_data_valid),
    .res_valid         (res_valid),
    .res_row           (res_row),
    .res_col           (res_col),
    .res_ack           (res_ack),
    .err               (err)
  );

  always #5 clk = ~clk;

  // conv_3x3 stand-in: a result appears L cycles after each last-channel issue;
  // the downstream writer frees its slot one cycle after each result.
  logic [L-1:0] pipe = '0;
  logic         ack_pend = 1'b0;
  always @(negedge clk) begin
    pipe      = {pipe[L-2:0], conv_valid_in & conv_last_channel};
    model_dv  = pipe[L-1];
    model_ack = ack_en & ack_pend;
    ack_pend  = model_dv;
  end

  int          cyc = 0, n_issue = 0, n_last = 0, n_res = 0, n_take = 0, bad_take = 0;
  logic [19:0] tag_log  [64];
  logic [5:0]  take_grp [128];
  int          take_cyc [128];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (conv_valid_in) n_issue <= n_issue + 1;
    if (conv_valid_in && conv_last_channel) n_last <= n_last + 1;
    if (res_valid) begin
      if (n_res < 64) tag_log[n_res] <= {res_row, res_col};
      n_res <= n_res + 1;
    end
    if (win_take) begin
      if (n_take < 128) begin
        take_grp[n_take] <= cur_grp;
        take_cyc[n_take] <= cyc;
      end
      n_take <= n_take + 1;
      if (!win_ready) bad_take <= bad_take + 1;
    end
  end

  int compared = 0, mismatched = 0;
  int b_issue, b_last, b_res, b_take, b_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    b_issue = n_issue; b_last = n_last; b_res = n_res; b_take = n_take; b_bad = bad_take;
  endtask

  task automatic do_start(input int g, input int w, input int h);
    cfg_cin_groups = CG_W'(g);
    cfg_width      = DIM_W'(w);
    cfg_height     = DIM_W'(h);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic pulse_ack();
    tb_ack = 1'b1;
    tick(1);
    tb_ack = 1'b0;
    tick(1);
  endtask

  initial begin
    // reset state
    win_ready = 1'b1;
    tick(2);
    check("reset_flags", 32'({busy, done, win_take, conv_valid_in, conv_last_channel, res_valid, err}), 32'd0);
    check("reset_pos", 32'({cur_row, cur_col, cur_grp}), 32'd0);
    check("reset_tag", 32'({res_row, res_col}), 32'd0);
    rst = 1'b0;
    tick(1);

    // 2x2 tile, one group per pixel
    ack_en = 1'b1;
    snap();
    do_start(1, 2, 2);
    wait_done("t1_done", 200);
    check("t1_issues", 32'(n_issue - b_issue), 32'd4);
    check("t1_lasts", 32'(n_last - b_last), 32'd4);
    check("t1_results", 32'(n_res - b_res), 32'd4);
    check("t1_tag0", 32'(tag_log[b_res]),   32'h00000);
    check("t1_tag1", 32'(tag_log[b_res+1]), 32'h00001);
    check("t1_tag2", 32'(tag_log[b_res+2]), 32'h00400);
    check("t1_tag3", 32'(tag_log[b_res+3]), 32'h00401);
    check("t1_busy_low", 32'(busy), 32'd0);
    check("t1_err", 32'(err), 32'd0);

    // three groups on a single pixel
    tick(2);
    snap();
    do_start(3, 1, 1);
    wait_done("t2_done", 100);
    check("t2_issues", 32'(n_issue - b_issue), 32'd3);
    check("t2_lasts", 32'(n_last - b_last), 32'd1);
    check("t2_results", 32'(n_res - b_res), 32'd1);
    check("t2_tag", 32'(tag_log[b_res]), 32'h00000);
    check("t2_grp_seq", 32'({take_grp[b_take], take_grp[b_take+1], take_grp[b_take+2]}), 32'h00042);
    check("t2_back_to_back", 32'(take_cyc[b_take+2] - take_cyc[b_take]), 32'd2);

    // credit throttle, acks only by hand
    ack_en = 1'b0;
    tick(3);
    snap();
    do_start(1, 8, 1);
    tick(20);
    check("t3_issues_stalled", 32'(n_issue - b_issue), 32'd4);
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_no_take", 32'(win_take), 32'd0);
    check("t3_col", 32'(cur_col), 32'd4);
    pulse_ack();
    pulse_ack();
    tick(10);
    check("t3_issues_released", 32'(n_issue - b_issue), 32'd6);
    pulse_ack();
    pulse_ack();
    wait_done("t3_done", 100);
    check("t3_issues_total", 32'(n_issue - b_issue), 32'd8);
    check("t3_results", 32'(n_res - b_res), 32'd8);
    check("t3_tag_last", 32'(tag_log[b_res+7]), 32'h00007);
    repeat (4) pulse_ack();
    check("t3_err", 32'(err), 32'd0);

    // win_ready toggling 1010...
    ack_en = 1'b1;
    win_ready = 1'b0;
    tick(2);
    snap();
    do_start(2, 2, 1);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 80 && !seen; i++) begin
        win_ready = (i % 2 == 0);
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      check("t4_done", 32'(seen), 32'd1);
    end
    win_ready = 1'b1;
    check("t4_takes", 32'(n_take - b_take), 32'd4);
    check("t4_no_unready_take", 32'(bad_take - b_bad), 32'd0);
    check("t4_take_spacing", 32'(take_cyc[b_take+3] - take_cyc[b_take]), 32'd6);
    check("t4_results", 32'(n_res - b_res), 32'd2);

    // zero height finishes without issuing
    tick(2);
    snap();
    do_start(1, 1, 0);
    check("t5_done_not_yet", 32'({done, busy}), 32'b01);
    tick(1);
    check("t5_done_pulse", 32'({done, busy}), 32'b10);
    tick(1);
    check("t5_done_one_cycle", 32'(done), 32'd0);
    check("t5_no_issue", 32'(n_issue - b_issue), 32'd0);

    // start while running is ignored
    win_ready = 1'b0;
    tick(1);
    snap();
    do_start(1, 4, 1);
    tick(3);
    do_start(1, 1, 1);
    check("t6_still_busy", 32'(busy), 32'd1);
    win_ready = 1'b1;
    wait_done("t6_done", 100);
    check("t6_issues", 32'(n_issue - b_issue), 32'd4);
    check("t6_tag_last", 32'(tag_log[b_res+3]), 32'h00003);

    // simultaneous last-group take and ack at credits == 1
    ack_en = 1'b0;
    tick(3);
    snap();
    do_start(1, 8, 1);
    tick(10);
    check("t7_issues_4", 32'(n_issue - b_issue), 32'd4);
    win_ready = 1'b0;
    pulse_ack();
    win_ready = 1'b1;
    tb_ack = 1'b1;
    tick(1);
    win_ready = 1'b0;
    tb_ack = 1'b0;
    tick(2);
    check("t7_issues_5", 32'(n_issue - b_issue), 32'd5);
    win_ready = 1'b1;
    tick(6);
    check("t7_credit_kept", 32'(n_issue - b_issue), 32'd6);
    check("t7_err_clean", 32'(err), 32'd0);
    pulse_ack();
    pulse_ack();
    wait_done("t7_done", 100);
    repeat (4) pulse_ack();
    check("t7_err_after", 32'(err), 32'd0);

    // spurious result with nothing in flight
    tick(2);
    tb_dv = 1'b1;
    tick(1);
    tb_dv = 1'b0;
    check("t8_err_set", 32'(err), 32'd1);
    tick(2);
    check("t8_err_sticky", 32'(err), 32'd1);

    // reset in the middle of a tile
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t9_rst_clears_err", 32'(err), 32'd0);
    win_ready = 1'b1;
    snap();
    do_start(1, 4, 1);
    tick(2);
    rst = 1'b1;
    #1;
    check("t9_rst_flags", 32'({busy, done, win_take, conv_valid_in, conv_last_channel, err}), 32'd0);
    check("t9_rst_pos", 32'({cur_row, cur_col, cur_grp}), 32'd0);
    check("t9_rst_tag", 32'({res_row, res_col}), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(8);
    check("t9_orphan_err", 32'(err), 32'd1);
    check("t9_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/conv_3x3_sched.md
Name: conv_3x3_sched

Overview:
Sequencer for the conv_3x3 8-filter, 8-channel MAC datapath.
- Walks an output tile row-major (row, col) with input-channel groups innermost.
- Issues one conv valid_in pulse per 8-channel group and flags the final group with last_channel.
- Tags every in-flight output with its (row, col) and throttles issue against downstream buffer credits, because conv_3x3 has no stall input.
- Sits between the line/window buffer plus weight store and conv_3x3; its result tags feed the requant/output writer.

Parameters:
- CG_W, 6: width of channel-group count and index.
- DIM_W, 10: width of row/col counters and tile dimensions.
- CREDITS, 4: downstream result-buffer slots; also the depth of the tag FIFO.
- CRED_W, 3: credit counter width; must satisfy 2^CRED_W > CREDITS.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; latches cfg_* when the block is idle
- cfg_cin_groups  in  CG_W  input channels / 8
- cfg_width  in  DIM_W  output columns
- cfg_height  in  DIM_W  output rows
- busy  out  1  high from the start accept until done
- done  out  1  one-cycle pulse when the tile is complete
- win_ready  in  1  window buffer and weight store can present the current (row, col, grp)
- win_take  out  1  combinational; current item consumed this cycle
- cur_row, cur_col  out  DIM_W  current position (counters)
- cur_grp  out  CG_W  current channel group (counter)
- conv_valid_in  out  1  to conv_3x3 valid_in
- conv_last_channel  out  1  to conv_3x3 last_channel
- conv_data_valid  in  1  from conv_3x3 data_valid
- res_valid  out  1  equals conv_data_valid
- res_row, res_col  out  DIM_W  tag FIFO head
- res_ack  in  1  downstream freed one buffer slot
- err  out  1  sticky protocol error

Behaviour:
Reset values
- All outputs 0.
- State = IDLE; credits = CREDITS; tag FIFO empty.
- rst may assert mid-tile: all state clears immediately, in-flight conv results are later flagged as an error by the empty-FIFO rule.

FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE: start latches cfg and clears counters.
  - Any cfg field equal to 0 -> FIN with no issues.
  - Otherwise -> RUN.
  - start while not IDLE is ignored.
- RUN: win_take = win_ready && (cur_grp != cfg_cin_groups-1 || credits != 0).
  - On win_take, cur_grp increments.
  - At the last group: cur_grp wraps to 0 and cur_col increments.
  - At the last col: cur_col wraps to 0 and cur_row increments.
  - At the last group of the last pixel -> DRAIN.
- DRAIN: wait until the tag FIFO is empty -> FIN.
- FIN: done=1 for exactly one cycle -> IDLE.
- busy = (state != IDLE).

Issue timing
- conv_valid_in is registered: asserted the cycle after win_take, so it aligns with the buffers presenting data one cycle later.
- conv_last_channel is registered alongside it: 1 iff the taken item was the last group.
- A last-group take, in the same cycle:
  - pushes (cur_row, cur_col) into the tag FIFO;
  - decrements credits.
- Back-to-back issues every cycle are allowed.

Result path
- conv_data_valid pops the FIFO.
- res_valid and res_row/res_col are combinational from conv_data_valid and the FIFO head.

Credit accounting
- res_ack increments credits.
- A simultaneous last-group take and res_ack leaves credits unchanged.
- res_ack with credits == CREDITS is ignored and sets err.

Error conditions
- conv_data_valid with an empty FIFO sets err (no pop).
- A push to a full FIFO cannot occur, because credits bound it.
- err is sticky and cleared only by rst.

Optional Feature:
Macro: CONV_SCHED_PERF_EN
- Defined: adds output stall_cycles [31:0], a counter cleared on start accept. It increments on each RUN cycle with no win_take; it is split into two further outputs:
  - credit_stalls [31:0]: win_ready=1 but blocked by credits;
  - data_stalls [31:0]: win_ready=0.
- Undefined: these ports and counters do not exist.
- Scheduling is identical either way.

Test Plan:
- cfg groups=1, width=2, height=2; win_ready=1; res_ack one cycle after each res_valid; conv model (latency L) returns 72 per filter.
  - Expect 4 conv_valid_in pulses, all with last_channel=1.
  - Tags in order (0,0), (0,1), (1,0), (1,1); done after the 4th result; err=0.
- groups=3, width=1, height=1: 3 consecutive conv_valid_in pulses with last_channel only on the 3rd; cur_grp sequence 0, 1, 2; exactly one result tag (0,0).
- Credit throttle: CREDITS=4, groups=1, width=8, height=1, res_ack never asserted.
  - Exactly 4 issues, then stall in RUN.
  - Asserting res_ack twice releases exactly 2 more issues.
- win_ready toggling 1010..., groups=2, width=2: takes occur only on win_ready=1 cycles; the final tag count is 2.
- Edge cases:
  - cfg_height=0 -> done 2 cycles after start, no conv_valid_in.
  - start during RUN -> ignored.
  - rst mid-RUN -> outputs 0; a later conv_data_valid sets err.
- Simultaneous last-group take and res_ack with credits=1 -> credits stays 1.
  - Also: a spurious conv_data_valid with an empty FIFO sets err.
